neopixel_strand_ctrl_param: RTL and testbench

NEOPIXEL_STRAND_CTRL_PARAM -- requirements
Module: neopixel_strand_ctrl_param

---
 rtl/neopixel_strand_ctrl_param.sv | 227 ++++++++++++++++++++++
 tb/tb_neopixel_strand_ctrl_param.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/neopixel_strand_ctrl_param.sv
`default_nettype none
// ============================================================================
// Module      : neopixel_strand_ctrl_param
// Description : Frame buffer and serial driver for a WS2812-style LED strand.
//               Holds an 8-bit G/R/B level for each of NUM_PIXELS pixels.
//               On send_it it shifts the whole strand out on neo_data, pixel 0
//               first, G then R then B, MSB first. Each byte is dimmed by a
//               right shift that is captured when the frame starts. The frame
//               ends with a TRESET-clock low latch period and a send_done pulse.
// Ports       : clock            - single clock, rising edge
//               reset_n          - asynchronous active-low reset
//               load_color       - write color_level to the selected channel
//               broadcast        - with load_color, write that channel of every pixel
//               pixel_index      - target pixel
//               color_index      - 00 red, 01 blue, 10 green, 11 ignored
//               color_level      - channel intensity
//               brightness_shift - global dimming shift, captured at frame start
//               send_it          - start one frame
//               neo_data         - registered serial line to the strand
//               ready_to_load    - loads are accepted this cycle
//               ready_to_send    - send_it is accepted this cycle
//               send_done        - one-cycle pulse on the first idle cycle after a frame
// Revision    : 1.0 - initial release
// ============================================================================
module neopixel_strand_ctrl_param #(
    parameter int  NUM_PIXELS = 8,
    parameter int  T0H        = 18,
    parameter int  T1H        = 35,
    parameter int  TBIT       = 63,
    parameter int  TRESET     = 2500,
    localparam int PW         = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          load_color,
    input  logic          broadcast,
    input  logic [PW-1:0] pixel_index,
    input  logic [1:0]    color_index,
    input  logic [7:0]    color_level,
    input  logic [2:0]    brightness_shift,
    input  logic          send_it,
    output logic          neo_data,
    output logic          ready_to_load,
    output logic          ready_to_send,
    output logic          send_done
);

    localparam int c_NBITS  = NUM_PIXELS * 24;
    localparam int c_TICK_W = (TBIT > 1) ? $clog2(TBIT) : 1;
    localparam int c_BIT_W  = $clog2(c_NBITS);
    localparam int c_LAT_W  = (TRESET > 1) ? $clog2(TRESET) : 1;

    localparam logic [c_TICK_W-1:0] c_TICK_LAST  = c_TICK_W'(TBIT - 1);
    localparam logic [c_BIT_W-1:0]  c_BIT_LAST   = c_BIT_W'(c_NBITS - 1);
    localparam logic [c_LAT_W-1:0]  c_LATCH_LAST = c_LAT_W'(TRESET - 1);
    localparam logic [c_TICK_W:0]   c_T0H        = (c_TICK_W + 1)'(T0H);
    localparam logic [c_TICK_W:0]   c_T1H        = (c_TICK_W + 1)'(T1H);

    // ------------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------------
    if (!((T0H > 0) && (T0H < T1H) && (T1H < TBIT))) begin : g_bad_timing
        $fatal(1, "neopixel_strand_ctrl_param: need 0 < T0H < T1H < TBIT");
    end
    if ((NUM_PIXELS < 2) || (NUM_PIXELS > 256)) begin : g_bad_pixels
        $fatal(1, "neopixel_strand_ctrl_param: NUM_PIXELS must be 2..256");
    end
    if (TRESET < 1) begin : g_bad_reset_time
        $fatal(1, "neopixel_strand_ctrl_param: TRESET must be at least 1");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SEND  = 2'd1,
        S_LATCH = 2'd2
    } state_t;

    state_t                r_state;
    logic [7:0]            r_lvl_g [NUM_PIXELS];
    logic [7:0]            r_lvl_r [NUM_PIXELS];
    logic [7:0]            r_lvl_b [NUM_PIXELS];
    logic [2:0]            r_shift;
    logic [c_TICK_W-1:0]   r_tick;      // clock within the current bit
    logic [c_BIT_W-1:0]    r_bit_cnt;   // bit number within the frame
    logic [c_LAT_W-1:0]    r_latch;     // clock within the latch period
    logic [PW-1:0]         r_pix;       // pixel being sent
    logic [1:0]            r_chan;      // 0 G, 1 R, 2 B (wire order)
    logic [2:0]            r_bit_idx;   // 0 = MSB of the current byte

    logic                  w_write;
    logic [7:0]            w_level;
    logic [7:0]            w_byte;
    logic                  w_bit;
    logic [c_TICK_W:0]     w_high_time;
    logic [c_TICK_W:0]     w_tick_nxt;

    assign ready_to_load = (r_state == S_IDLE);
    assign ready_to_send = (r_state == S_IDLE);

    // A send on the same edge wins over a load.
    assign w_write = (r_state == S_IDLE) && load_color && !send_it &&
                     (color_index != 2'b11);

    // ------------------------------------------------------------------------
    // Frame storage
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int p = 0; p < NUM_PIXELS; p++) begin
                r_lvl_g[p] <= 8'h00;
                r_lvl_r[p] <= 8'h00;
                r_lvl_b[p] <= 8'h00;
            end
        end else if (w_write) begin
            for (int p = 0; p < NUM_PIXELS; p++) begin
                if (broadcast || (pixel_index == PW'(p))) begin
                    case (color_index)
                        2'b00:   r_lvl_r[p] <= color_level;
                        2'b01:   r_lvl_b[p] <= color_level;
                        2'b10:   r_lvl_g[p] <= color_level;
                        default: ;
                    endcase
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Current bit selection
    // ------------------------------------------------------------------------
    always_comb begin
        w_level = r_lvl_g[r_pix];
        case (r_chan)
            2'd1:    w_level = r_lvl_r[r_pix];
            2'd2:    w_level = r_lvl_b[r_pix];
            default: w_level = r_lvl_g[r_pix];
        endcase
    end

    assign w_byte      = w_level >> r_shift;
    assign w_bit       = w_byte[3'd7 - r_bit_idx];
    assign w_high_time = w_bit ? c_T1H : c_T0H;
    assign w_tick_nxt  = {1'b0, r_tick} + {{c_TICK_W{1'b0}}, 1'b1};

    // ------------------------------------------------------------------------
    // Transmit state machine. neo_data is registered and always reflects the
    // value for the clock tick the counters will hold after this edge.
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            neo_data  <= 1'b0;
            send_done <= 1'b0;
            r_shift   <= 3'd0;
            r_tick    <= '0;
            r_bit_cnt <= '0;
            r_latch   <= '0;
            r_pix     <= '0;
            r_chan    <= 2'd0;
            r_bit_idx <= 3'd0;
        end else begin
            send_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    neo_data <= 1'b0;
                    if (send_it) begin
                        r_state   <= S_SEND;
                        r_shift   <= brightness_shift;
                        r_tick    <= '0;
                        r_bit_cnt <= '0;
                        r_pix     <= '0;
                        r_chan    <= 2'd0;
                        r_bit_idx <= 3'd0;
                        // Every bit starts high since T0H > 0.
                        neo_data  <= 1'b1;
                    end
                end

                S_SEND: begin
                    if (r_tick == c_TICK_LAST) begin
                        r_tick <= '0;
                        if (r_bit_cnt == c_BIT_LAST) begin
                            r_state  <= S_LATCH;
                            r_latch  <= '0;
                            neo_data <= 1'b0;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + {{(c_BIT_W-1){1'b0}}, 1'b1};
                            neo_data  <= 1'b1;
                            if (r_bit_idx == 3'd7) begin
                                r_bit_idx <= 3'd0;
                                if (r_chan == 2'd2) begin
                                    r_chan <= 2'd0;
                                    r_pix  <= r_pix + {{(PW-1){1'b0}}, 1'b1};
                                end else begin
                                    r_chan <= r_chan + 2'd1;
                                end
                            end else begin
                                r_bit_idx <= r_bit_idx + 3'd1;
                            end
                        end
                    end else begin
                        r_tick   <= w_tick_nxt[c_TICK_W-1:0];
                        neo_data <= (w_tick_nxt < w_high_time);
                    end
                end

                S_LATCH: begin
                    neo_data <= 1'b0;
                    if (r_latch == c_LATCH_LAST) begin
                        r_state   <= S_IDLE;
                        r_latch   <= '0;
                        send_done <= 1'b1;
                    end else begin
                        r_latch <= r_latch + {{(c_LAT_W-1){1'b0}}, 1'b1};
                    end
                end

                default: begin
                    r_state  <= S_IDLE;
                    neo_data <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_neopixel_strand_ctrl_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_neopixel_strand_ctrl_param
// Description : Self-checking bench for neopixel_strand_ctrl_param with a
//               4-pixel strand and short bit timings. A frame-buffer model
//               predicts every transmitted byte; the captured serial line is
//               decoded back into bytes and compared.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_neopixel_strand_ctrl_param;

    localparam int NP    = 4;
    localparam int T0    = 2;
    localparam int T1    = 4;
    localparam int TB    = 6;
    localparam int TR    = 10;
    localparam int PW    = 2;
    localparam int NBITS = NP * 24;
    localparam int NBYTE = NP * 3;
    localparam int FRAME = NBITS * TB;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          load_color = 1'b0;
    logic          broadcast = 1'b0;
    logic [PW-1:0] pixel_index = '0;
    logic [1:0]    color_index = 2'b00;
    logic [7:0]    color_level = 8'h00;
    logic [2:0]    brightness_shift = 3'd0;
    logic          send_it = 1'b0;
    logic          neo_data;
    logic          ready_to_load;
    logic          ready_to_send;
    logic          send_done;

    int checks   = 0;
    int failures = 0;

    logic [7:0] m_g [NP];
    logic [7:0] m_r [NP];
    logic [7:0] m_b [NP];

    neopixel_strand_ctrl_param #(
        .NUM_PIXELS (NP),
        .T0H        (T0),
        .T1H        (T1),
        .TBIT       (TB),
        .TRESET     (TR)
    ) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .load_color       (load_color),
        .broadcast        (broadcast),
        .pixel_index      (pixel_index),
        .color_index      (color_index),
        .color_level      (color_level),
        .brightness_shift (brightness_shift),
        .send_it          (send_it),
        .neo_data         (neo_data),
        .ready_to_load    (ready_to_load),
        .ready_to_send    (ready_to_send),
        .send_done        (send_done)
    );

    always #5 clock = ~clock;

    function automatic void model_clear();
        for (int p = 0; p < NP; p++) begin
            m_g[p] = 8'h00;
            m_r[p] = 8'h00;
            m_b[p] = 8'h00;
        end
    endfunction

    // One load request held for a single rising edge while idle.
    task automatic do_load(input int p, input int ci, input logic [7:0] lvl, input bit bc);
        @(negedge clock);
        load_color  = 1'b1;
        broadcast   = bc;
        pixel_index = PW'(p);
        color_index = 2'(ci);
        color_level = lvl;
        checks++;
        if (ready_to_load !== 1'b1) begin
            failures++;
            $display("FAIL load_ready: got %b expected 1", ready_to_load);
        end
        @(negedge clock);
        load_color = 1'b0;
        broadcast  = 1'b0;
        if (ci != 3) begin
            for (int i = 0; i < NP; i++) begin
                if (bc || i == p) begin
                    if (ci == 0) m_r[i] = lvl;
                    else if (ci == 1) m_b[i] = lvl;
                    else m_g[i] = lvl;
                end
            end
        end
    endtask

    // Sends one frame, captures neo_data every cycle and checks it against
    // the model. disturb pokes every input during SEND and LATCH; coincident
    // drives a load on the same edge as send_it.
    task automatic run_frame(input logic [2:0] shift, input bit disturb,
                             input bit coincident, input string name);
        logic [7:0] exp_b [NBYTE];
        logic [7:0] got_b [NBYTE];
        logic       s [FRAME];
        int         busy_err;
        int         latch_err;
        int         bad;

        for (int p = 0; p < NP; p++) begin
            exp_b[p*3 + 0] = m_g[p] >> shift;
            exp_b[p*3 + 1] = m_r[p] >> shift;
            exp_b[p*3 + 2] = m_b[p] >> shift;
        end
        busy_err  = 0;
        latch_err = 0;
        bad       = 0;

        @(negedge clock);
        checks++;
        if (ready_to_send !== 1'b1) begin
            failures++;
            $display("FAIL %s send_ready: got %b expected 1", name, ready_to_send);
        end
        brightness_shift = shift;
        send_it          = 1'b1;
        if (coincident) begin
            load_color  = 1'b1;
            broadcast   = 1'($urandom_range(0, 1));
            pixel_index = PW'($urandom_range(0, NP - 1));
            color_index = 2'($urandom_range(0, 2));
            color_level = 8'($urandom_range(1, 255));
        end

        for (int c = 0; c < FRAME; c++) begin
            @(negedge clock);
            if (c == 0) begin
                send_it    = 1'b0;
                load_color = 1'b0;
                broadcast  = 1'b0;
            end
            s[c] = neo_data;
            if (ready_to_send !== 1'b0 || ready_to_load !== 1'b0 || send_done !== 1'b0)
                busy_err++;
            if (disturb && c == 100) begin
                send_it          = 1'b1;
                load_color       = 1'b1;
                broadcast        = 1'b1;
                color_index      = 2'b00;
                color_level      = 8'h5A;
                brightness_shift = ~shift;
            end
            if (disturb && c == 102) begin
                send_it    = 1'b0;
                load_color = 1'b0;
                broadcast  = 1'b0;
            end
        end

        for (int c = 0; c < TR; c++) begin
            @(negedge clock);
            if (neo_data !== 1'b0 || ready_to_send !== 1'b0 ||
                ready_to_load !== 1'b0 || send_done !== 1'b0)
                latch_err++;
            if (disturb && c == 3) begin
                send_it     = 1'b1;
                load_color  = 1'b1;
                pixel_index = 2'd1;
                color_index = 2'b10;
                color_level = 8'hC3;
            end
            if (disturb && c == 4) begin
                send_it    = 1'b0;
                load_color = 1'b0;
            end
        end

        @(negedge clock);
        checks++;
        if (send_done !== 1'b1 || ready_to_send !== 1'b1) begin
            failures++;
            $display("FAIL %s done_pulse: got done=%b ready=%b expected done=1 ready=1",
                     name, send_done, ready_to_send);
        end
        @(negedge clock);
        checks++;
        if (send_done !== 1'b0) begin
            failures++;
            $display("FAIL %s done_width: got %b expected 0", name, send_done);
        end

        // Decode: each bit must be a run of ones followed by zeros.
        for (int k = 0; k < NBITS; k++) begin
            int h;
            bit clean;
            h     = 0;
            clean = 1'b1;
            for (int j = 0; j < TB; j++) begin
                if (s[k*TB + j]) begin
                    if (h != j) clean = 1'b0;
                    h++;
                end
            end
            if (!clean || (h != T0 && h != T1)) bad++;
            got_b[k/8][7 - (k%8)] = (h == T1);
        end

        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL %s bit_shape: got %0d malformed bits expected 0", name, bad);
        end
        checks++;
        if (busy_err !== 0) begin
            failures++;
            $display("FAIL %s busy_outputs: got %0d bad cycles expected 0", name, busy_err);
        end
        checks++;
        if (latch_err !== 0) begin
            failures++;
            $display("FAIL %s latch: got %0d bad cycles expected 0", name, latch_err);
        end
        for (int i = 0; i < NBYTE; i++) begin
            checks++;
            if (got_b[i] !== exp_b[i]) begin
                failures++;
                $display("FAIL %s byte%0d: got %h expected %h", name, i, got_b[i], exp_b[i]);
            end
        end
    endtask

    task automatic test_reset();
        model_clear();
        reset_n = 1'b0;
        #2;
        checks++;
        if (neo_data !== 1'b0 || send_done !== 1'b0 ||
            ready_to_load !== 1'b1 || ready_to_send !== 1'b1) begin
            failures++;
            $display("FAIL reset_outputs: got neo=%b done=%b rl=%b rs=%b expected 0 0 1 1",
                     neo_data, send_done, ready_to_load, ready_to_send);
        end
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_all_zero();
        run_frame(3'd0, 1'b0, 1'b0, "zero_frame");
    endtask

    task automatic test_directed_loads();
        do_load(2, 0, 8'hFF, 1'b0);
        do_load(1, 1, 8'hA0, 1'b0);
        do_load(3, 2, 8'hB3, 1'b0);
        do_load(1, 3, 8'hD4, 1'b0);
        run_frame(3'd0, 1'b0, 1'b0, "directed");
    endtask

    task automatic test_broadcast_shift();
        do_load(0, 2, 8'h81, 1'b1);
        run_frame(3'd1, 1'b0, 1'b0, "broadcast");
    endtask

    task automatic test_random();
        for (int it = 0; it < 4; it++) begin
            for (int n = 0; n < 6; n++) begin
                do_load($urandom_range(0, NP - 1), $urandom_range(0, 3),
                        8'($urandom_range(0, 255)), ($urandom_range(0, 7) == 0));
            end
            run_frame(3'($urandom_range(0, 3)), 1'b0, 1'b0, "random");
        end
    endtask

    task automatic test_busy_ignore();
        run_frame(3'd0, 1'b1, 1'b0, "busy_ignore");
        run_frame(3'd0, 1'b0, 1'b0, "after_busy");
    endtask

    task automatic test_back_to_back();
        run_frame(3'd2, 1'b0, 1'b1, "coincident");
        run_frame(3'd0, 1'b0, 1'b0, "after_coincident");
    endtask

    task automatic test_mid_frame_reset();
        do_load(0, 2, 8'hFF, 1'b1);
        @(negedge clock);
        brightness_shift = 3'd0;
        send_it = 1'b1;
        for (int c = 0; c <= 204; c++) begin
            @(negedge clock);
            send_it = 1'b0;
        end
        // Clock 204 is the first tick of a bit, so the line is high.
        checks++;
        if (neo_data !== 1'b1) begin
            failures++;
            $display("FAIL midreset_pre: got %b expected 1", neo_data);
        end
        #2;
        reset_n = 1'b0;
        model_clear();
        #1;
        checks++;
        if (neo_data !== 1'b0 || ready_to_send !== 1'b1 ||
            ready_to_load !== 1'b1 || send_done !== 1'b0) begin
            failures++;
            $display("FAIL midreset_async: got neo=%b rs=%b rl=%b done=%b expected 0 1 1 0",
                     neo_data, ready_to_send, ready_to_load, send_done);
        end
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        begin
            int done_seen;
            done_seen = 0;
            repeat (40) begin
                @(negedge clock);
                if (send_done !== 1'b0 || neo_data !== 1'b0) done_seen++;
            end
            checks++;
            if (done_seen !== 0) begin
                failures++;
                $display("FAIL midreset_quiet: got %0d active cycles expected 0", done_seen);
            end
        end
        run_frame(3'd0, 1'b0, 1'b0, "after_reset");
    endtask

    initial begin
        test_reset();
        test_all_zero();
        test_directed_loads();
        test_broadcast_shift();
        test_random();
        test_busy_ignore();
        test_back_to_back();
        test_mid_frame_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
